// File: rtl/acc_bus_pkg.sv
// acc_bus_pkg: shared widths and helper constants for the acc_* bus.
// Used by acc_mem_responder and by the initiators that talk to it.
package acc_bus_pkg;

    localparam int ACC_DATA_W = 256;
    localparam int ACC_ADDR_W = 19;
    localparam int ACC_STRB_W = ACC_DATA_W / 8;

    // A request with no byte enabled is a read.
    localparam logic [ACC_STRB_W-1:0] ACC_RD_OP = '0;

    // Width of the read-latency down-counter (latency 1..15).
    localparam int ACC_LAT_W = 4;

endpackage

// File: rtl/acc_mem_array.sv
// acc_mem_array: DEPTH x DATA_WIDTH storage with one byte-enabled
// write port and one registered read port that holds its last value.
module acc_mem_array
    import acc_bus_pkg::*;
#(
    parameter int DATA_WIDTH = ACC_DATA_W,
    parameter int DEPTH      = 1024,
    localparam int IDX_W     = $clog2(DEPTH),
    localparam int STRB_W    = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [STRB_W-1:0]     wstrb,
    input  logic [IDX_W-1:0]      idx,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic                  rd_zero,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Byte-enabled write; bytes with a clear strobe keep their value.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb[i]) begin
                    mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    // Read snapshot: only updated on a read, so later writes cannot alter it.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= rd_zero ? '0 : mem[idx];
        end
    end

endmodule

// File: rtl/acc_mem_responder.sv
// acc_mem_responder: memory responder on the acc_* bus, fixed read latency.
// Define ACC_MEM_ERR_EN to add the acc_err out-of-range flag port.
module acc_mem_responder
    import acc_bus_pkg::*;
#(
    parameter int DATA_WIDTH   = ACC_DATA_W,
    parameter int ADDR_WIDTH   = ACC_ADDR_W,
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    acc_valid,
    input  logic [ADDR_WIDTH-1:0]   acc_addr,
    input  logic [DATA_WIDTH-1:0]   acc_wdata,
    input  logic [DATA_WIDTH/8-1:0] acc_wstrb,
    output logic                    acc_ready,
    output logic [DATA_WIDTH-1:0]   acc_rdata,
    output logic                    acc_rvalid
`ifdef ACC_MEM_ERR_EN
    ,
    output logic                    acc_err
`endif
);

    localparam int IDX_W = $clog2(DEPTH);

    logic                  pending;
    logic [ACC_LAT_W-1:0]  lat_cnt;
    logic                  is_rd;
    logic                  in_range;
    logic                  accept;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  fire;
    logic [DATA_WIDTH-1:0] snap;

    assign is_rd    = (acc_wstrb == '0);
    assign in_range = (acc_addr < ADDR_WIDTH'(DEPTH));

    // Reads wait for the outstanding one; writes always go through.
    // Never accept while acc_ready is high, so it stays a single pulse.
    assign accept = rst_n && acc_valid && !acc_ready
                    && (!is_rd || !pending);
    assign rd_acc = accept && is_rd;
    assign wr_acc = accept && !is_rd;
    assign fire   = pending && (lat_cnt == '0);

    acc_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we      (wr_acc && in_range),
        .wstrb   (acc_wstrb),
        .idx     (acc_addr[IDX_W-1:0]),
        .wdata   (acc_wdata),
        .re      (rd_acc),
        .rd_zero (!in_range),
        .rdata   (snap)
    );

    // Accept pulse, pending read tracking and latency countdown.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_ready  <= 1'b0;
            acc_rvalid <= 1'b0;
            acc_rdata  <= '0;
            pending    <= 1'b0;
            lat_cnt    <= '0;
        end else begin
            acc_ready  <= accept;
            acc_rvalid <= fire;
            if (fire) begin
                acc_rdata <= snap;
            end
            if (rd_acc) begin
                pending <= 1'b1;
                lat_cnt <= ACC_LAT_W'(READ_LATENCY - 1);
            end else if (fire) begin
                pending <= 1'b0;
            end else if (pending) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
        end
    end

`ifdef ACC_MEM_ERR_EN
    logic pend_oor;

    // Out-of-range flag: with acc_ready for writes, with acc_rvalid for reads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_err  <= 1'b0;
            pend_oor <= 1'b0;
        end else begin
            if (rd_acc) begin
                pend_oor <= !in_range;
            end
            acc_err <= (wr_acc && !in_range) || (fire && pend_oor);
        end
    end
`endif

endmodule

// File: tb/tb_acc_mem_responder.sv
// tb_acc_mem_responder: directed scoreboard bench for acc_mem_responder.
// Also checks acc_err when built with ACC_MEM_ERR_EN.
module tb_acc_mem_responder;

    localparam int DW    = 256;
    localparam int AW    = 19;
    localparam int SW    = DW / 8;
    localparam int DEPTH = 1024;
    localparam int RL    = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          acc_valid = 1'b0;
    logic [AW-1:0] acc_addr = '0;
    logic [DW-1:0] acc_wdata = '0;
    logic [SW-1:0] acc_wstrb = '0;
    logic          acc_ready;
    logic [DW-1:0] acc_rdata;
    logic          acc_rvalid;
`ifdef ACC_MEM_ERR_EN
    logic          acc_err;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int rv_count = 0;
    int n_reads  = 0;
    int cyc      = 0;
    logic prev_ready = 1'b0;

    logic [DW-1:0] exp_q [$];
    int            cyc_q [$];
    logic          err_q [$];

    acc_mem_responder #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .DEPTH        (DEPTH),
        .READ_LATENCY (RL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .acc_valid  (acc_valid),
        .acc_addr   (acc_addr),
        .acc_wdata  (acc_wdata),
        .acc_wstrb  (acc_wstrb),
        .acc_ready  (acc_ready),
        .acc_rdata  (acc_rdata),
        .acc_rvalid (acc_rvalid)
`ifdef ACC_MEM_ERR_EN
        ,
        .acc_err    (acc_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_data(input string tag, input logic [DW-1:0] obs,
                              input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response monitor: pops the scoreboard on every acc_rvalid.
    always @(posedge clk) begin
        #1;
        if (acc_ready === 1'b1) begin
            check_int("ready_single_pulse", int'(prev_ready), 0);
        end
        prev_ready = (acc_ready === 1'b1);
        if (acc_rvalid === 1'b1) begin
            rv_count++;
            check_int("rvalid_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                logic [DW-1:0] e;
                int            c;
                logic          er;
                e  = exp_q.pop_front();
                c  = cyc_q.pop_front();
                er = err_q.pop_front();
                check_data("rdata", acc_rdata, e);
                check_int("rvalid_latency", cyc - c, RL);
`ifdef ACC_MEM_ERR_EN
                check_int("rd_err", int'(acc_err), int'(er));
`else
                if (er) begin
                    rv_count = rv_count + 0;
                end
`endif
            end
        end
    end

    task automatic wait_ready(input string tag, output int rc);
        int n;
        n  = 0;
        rc = -1;
        while (n < 40) begin
            tick();
            n++;
            if (acc_ready === 1'b1) begin
                rc = cyc;
                break;
            end
        end
        acc_valid = 1'b0;
        n_assert++;
        assert (rc >= 0) else begin
            n_fail++;
            $error("FAIL %s_timeout observed=no acc_ready expected=acc_ready within 40 cycles", tag);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [SW-1:0] s, output int rc);
        acc_addr  = a;
        acc_wdata = d;
        acc_wstrb = s;
        acc_valid = 1'b1;
        wait_ready("write", rc);
`ifdef ACC_MEM_ERR_EN
        check_int("wr_err", int'(acc_err), int'(a >= AW'(DEPTH)));
`endif
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] e,
                           output int rc);
        acc_addr  = a;
        acc_wdata = '0;
        acc_wstrb = '0;
        acc_valid = 1'b1;
        wait_ready("read", rc);
        if (rc >= 0) begin
            exp_q.push_back(e);
            cyc_q.push_back(rc);
            err_q.push_back(a >= AW'(DEPTH));
            n_reads++;
        end
    endtask

    logic [DW-1:0] p16, w16, e16, p20, p21, p22, q22;
    logic [DW-1:0] a5, b5, ones, part, p1023, z0;
    int r1, r2, rw, rd;

    initial begin
        p16   = {8{32'hDEAD_BEEF}};
        w16   = {8{32'h7777_7777}};
        w16[31:0] = 32'h0000_001C;
        e16   = {p16[DW-1:32], 32'h0000_001C};
        p20   = {4{64'h0123_4567_89AB_CDEF}};
        p21   = {4{64'hFEDC_BA98_7654_3210}};
        p22   = {16{16'h2222}};
        q22   = {16{16'hC3C3}};
        a5    = {8{32'h5555_AAAA}};
        b5    = {8{32'h0BAD_F00D}};
        ones  = '1;
        part  = {{24{8'hFF}}, 32'h0000_0000, 32'hFFFF_FFFF};
        p1023 = {8{32'h1023_1023}};
        z0    = {8{32'h0000_0F0F}};

        repeat (3) tick();
        check_int("rst_ready", int'(acc_ready), 0);
        check_int("rst_rvalid", int'(acc_rvalid), 0);
        check_data("rst_rdata", acc_rdata, '0);
        rst_n = 1'b1;
        tick();

        do_write(19'd16, p16, '1, rw);
        do_write(19'd16, w16, 32'h0000_000F, rw);
        do_read(19'd16, e16, rd);
        repeat (RL + 2) tick();

        do_write(19'd20, p20, '1, rw);
        do_write(19'd21, p21, '1, rw);
        do_read(19'd20, p20, r1);
        do_read(19'd21, p21, r2);
        check_int("b2b_period", r2 - r1, RL + 1);
        repeat (RL + 2) tick();

        do_write(19'd5, a5, '1, rw);
        do_read(19'd5, a5, rd);
        do_write(19'd5, b5, '1, rw);
        check_int("wr_while_pending", rw - rd, 2);
        do_read(19'd5, b5, rd);
        repeat (RL + 2) tick();

        do_write(19'd22, p22, '1, rw);
        do_read(19'd22, p22, rd);
        tick();
        tick();
        do_write(19'd22, q22, '1, rw);
        check_int("wr_with_rvalid", rw - rd, RL);
        do_read(19'd22, q22, rd);
        repeat (RL + 2) tick();

        do_write(19'd1, ones, '1, rw);
        do_write(19'd1, '0, 32'h0000_00F0, rw);
        do_read(19'd1, part, rd);
        repeat (RL + 2) tick();

        do_write(19'd1023, p1023, '1, rw);
        do_write(19'd0, z0, '1, rw);
        do_write(19'd1024, ones, '1, rw);
        do_read(19'd1023, p1023, rd);
        do_read(19'd1024, '0, rd);
        do_read(19'd0, z0, rd);
        repeat (RL + 2) tick();

        do_read(19'd16, e16, rd);
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        void'(cyc_q.pop_back());
        void'(err_q.pop_back());
        n_reads--;
        tick();
        check_int("rst2_ready", int'(acc_ready), 0);
        check_int("rst2_rvalid", int'(acc_rvalid), 0);
        check_data("rst2_rdata", acc_rdata, '0);
        rst_n = 1'b1;
        repeat (RL + 4) tick();
        do_read(19'd16, e16, rd);
        do_read(19'd5, b5, rd);
        repeat (RL + 3) tick();

        check_int("queue_drained", exp_q.size(), 0);
        check_int("rvalid_count", rv_count, n_reads);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
